poisson_spike_encoder: RTL and testbench
========================================

# poisson_spike_encoder

Rate-to-spike encoder that consumes the 6-bit pseudo-random stream from the `lfsr` block and turns per-channel firing rates into stochastic spike events. It scans `N_CH` channels round-robin, one channel per enabled cycle. A channel fires when the random sample is below its programmed rate and the channel is not refractory. Fired channel addresses are queued in a small FIFO and presented on a valid/ready AER-style output for the downstream neuron array.

## Interface
- `N_CH`, 8: number of input channels, power of two, at least 2.
- `RATE_WID`, 6: width of rates and of the random sample; must equal the LFSR output width.
- `REFRAC_WID`, 4: width of the refractory counters.
- `FIFO_DEPTH`, 4: spike FIFO entries, power of two, at least 2.
- `DROP_WID`, 8: width of the drop counter.

Ports:
- `clk`  in  1  single clock; all state is updated on posedge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `en_i`  in  1  scan enable.
- `rate_i`  in  `N_CH*RATE_WID`  packed rates; channel k occupies `[k*RATE_WID +: RATE_WID]`.
- `refrac_i`  in  `REFRAC_WID`  refractory length, counted in visits to the channel.
- `rand_i`  in  `RATE_WID`  random sample from the `lfsr` output.
- `spike_valid_o`  out  1  FIFO non-empty.
- `spike_addr_o`  out  `$clog2(N_CH)`  channel address at the FIFO head.
- `spike_ready_i`  in  1  consumer accepts the head entry.
- `round_o`  out  1  one-cycle pulse when a scan round completes.
- `drop_cnt_o`  out  `DROP_WID`  saturating count of spikes lost because the FIFO was full.

## Operation
- State:
  - channel pointer `ch_q`
  - `N_CH` refractory counters `ref_q[k]`
  - FIFO storage, read pointer, write pointer and occupancy count
  - drop counter
- Reset (async, while `rst_i` = 1): `ch_q` = 0, all `ref_q` = 0, FIFO empty, `drop_cnt_o` = 0, `spike_valid_o` = 0, `spike_addr_o` = 0, `round_o` = 0.
- `en_i` = 0: pointer, refractory counters and drop counter hold, and no channel is evaluated. The FIFO still drains normally.
- When `en_i` = 1, each cycle evaluates channel c = `ch_q`:
  - `ref_q[c]` != 0: no fire; `ref_q[c]` decrements by 1.
  - `ref_q[c]` == 0 and unsigned `rand_i` < `rate[c]`: fire. `ref_q[c]` loads `refrac_i`.
  - Otherwise: no fire, and `ref_q[c]` stays 0.
  - `ch_q` increments and wraps from `N_CH-1` to 0. `round_o` is registered high for one cycle after the cycle that evaluates channel `N_CH-1`.
- Rate semantics:
  - Rate 0 never fires.
  - Rate r fires with probability r/2^RATE_WID per visit.
  - Rate 63 cannot fire when `rand_i` = 63.
  - `refrac_i` = 0 means no refractory period.
- Fire handling:
  - The address c is pushed into the FIFO if it is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the spike is dropped. `drop_cnt_o` increments, saturating at all-ones, and the refractory counter still loads.
- FIFO behaviour:
  - First-word-fall-through: `spike_addr_o` shows the head entry whenever `spike_valid_o` = 1.
  - A pop occurs when `spike_valid_o` && `spike_ready_i`.
  - Push and pop in the same cycle leave the occupancy unchanged.
  - When empty, `spike_addr_o` is don't-care and bench checks are gated by valid.
  - Ordering is strict FIFO.
- `rate_i` and `refrac_i` are sampled combinationally during the evaluating cycle. They may change at any time; no shadow registers are kept.

## Timing
- Fire evaluated in cycle t → entry visible on `spike_valid_o`/`spike_addr_o` in cycle t+1, when the FIFO was empty at t.
- `rand_i` is consumed in the same cycle it is presented. The upstream LFSR's registered output delay is not compensated.
- Scan period: `N_CH` enabled cycles per channel visit. A refractory period R blocks R visits, i.e. R*`N_CH` enabled cycles.
- Full FIFO: a fire with a simultaneous pop is accepted; a fire without a pop is dropped in that same cycle.
- `rst_i` asserted mid-operation: all state clears immediately and pending spikes are lost. The first evaluation after release is channel 0, on the first `clk` edge with `en_i` = 1.
- Throughput: at most 1 push and 1 pop per cycle.

## Test plan
- **Reset:** hold `rst_i` with random inputs → all outputs 0. Release with `en_i` = 0 for 10 cycles → no valid, `round_o` stays 0.
- **Deterministic fire:** `rate_i` channel 3 = 10, others 0, `rand_i` = 5, `refrac_i` = 0, `spike_ready_i` = 1 → valid pulses with addr 3 once every 8 cycles, one cycle after `ch_q` = 3. `round_o` pulses every 8 cycles.
- **Threshold boundary:** all rates = 20, `rand_i` = 20 → no spikes. `rand_i` = 19 → every channel fires, addrs 0..7 in order. All rates = 0 with `rand_i` = 0 → no spikes.
- **Refractory:** channel 0 rate 63, `rand_i` = 0, `refrac_i` = 2 → channel 0 fires on visits 1, 4, 7, i.e. 24 enabled cycles apart.
- **Backpressure and drops:** all rates 63, `rand_i` = 0, `refrac_i` = 0, `spike_ready_i` = 0 for 8 cycles → FIFO holds 0,1,2,3 and `drop_cnt_o` = 4. Raise ready → drains 0,1,2,3 in order while new pushes with simultaneous pops are accepted at full occupancy.
- **Saturation and async reset:** stall `spike_ready_i` for 300 enabled cycles → `drop_cnt_o` saturates at 255. Assert `rst_i` mid-cycle → counter and valid clear before the next clock edge.

Source files
------------

// File: rtl/poisson_spike_encoder.sv
// Poisson rate-to-spike encoder. It scans channels round-robin, fires when rand_i is
// below a channel's rate, applies a per-channel refractory period and queues fired
// addresses in a FWFT FIFO.
module poisson_spike_encoder #(
  parameter int unsigned N_CH       = 8,
  parameter int unsigned RATE_WID   = 6,
  parameter int unsigned REFRAC_WID = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_WID   = 8
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [N_CH*RATE_WID-1:0]     rate_i,
  input  logic [REFRAC_WID-1:0]        refrac_i,
  input  logic [RATE_WID-1:0]          rand_i,
  output logic                         spike_valid_o,
  output logic [$clog2(N_CH)-1:0]      spike_addr_o,
  input  logic                         spike_ready_i,
  output logic                         round_o,
  output logic [DROP_WID-1:0]          drop_cnt_o
);

  localparam int unsigned AW = $clog2(N_CH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]         ch_q, ch_d;
  logic [REFRAC_WID-1:0] ref_q [N_CH];
  logic [REFRAC_WID-1:0] ref_d [N_CH];
  logic [AW-1:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]         mem_d [FIFO_DEPTH];
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DROP_WID-1:0]   drop_q, drop_d;
  logic                  valid_q, valid_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  round_q, round_d;

  logic [RATE_WID-1:0]   rate_sel;
  logic                  fire, push, pop;

  // Channel evaluation, FIFO update and registered head/valid for the next cycle.
  always_comb begin
    ch_d     = ch_q;
    ref_d    = ref_q;
    mem_d    = mem_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    round_d  = 1'b0;
    fire     = 1'b0;
    rate_sel = rate_i[ch_q*RATE_WID +: RATE_WID];
    pop      = valid_q && spike_ready_i;

    if (en_i) begin
      ch_d    = AW'(ch_q + AW'(1));
      round_d = (ch_q == AW'(N_CH - 1));
      if (ref_q[ch_q] != '0) begin
        ref_d[ch_q] = REFRAC_WID'(ref_q[ch_q] - REFRAC_WID'(1));
      end else if (rand_i < rate_sel) begin
        fire        = 1'b1;
        ref_d[ch_q] = refrac_i;
      end
    end

    push = fire && ((cnt_q != CW'(FIFO_DEPTH)) || pop);

    if (fire && !push && (drop_q != '1)) begin
      drop_d = DROP_WID'(drop_q + DROP_WID'(1));
    end

    if (push) begin
      mem_d[wr_q] = ch_q;
      wr_d        = PW'(wr_q + PW'(1));
    end
    if (pop) begin
      rd_d = PW'(rd_q + PW'(1));
    end

    case ({push, pop})
      2'b10:   cnt_d = CW'(cnt_q + CW'(1));
      2'b01:   cnt_d = CW'(cnt_q - CW'(1));
      default: cnt_d = cnt_q;
    endcase

    valid_d = (cnt_d != '0);
    // The new head is the entry being written now if it lands on the read slot.
    addr_d  = (push && (wr_q == rd_d)) ? ch_q : mem_q[rd_d];
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ch_q    <= '0;
      ref_q   <= '{default: '0};
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      round_q <= 1'b0;
    end else begin
      ch_q    <= ch_d;
      ref_q   <= ref_d;
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      round_q <= round_d;
    end
  end

  assign spike_valid_o = valid_q;
  assign spike_addr_o  = addr_q;
  assign round_o       = round_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_poisson_spike_encoder.sv
// Self-checking bench for poisson_spike_encoder. A cycle model pushes the expected
// addresses into a scoreboard queue, and the bench compares them with the DUT output.
module tb_poisson_spike_encoder;

  localparam int unsigned N_CH       = 8;
  localparam int unsigned RATE_WID   = 6;
  localparam int unsigned REFRAC_WID = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DROP_WID   = 8;

  logic                     clk;
  logic                     rst_i;
  logic                     en_i;
  logic [N_CH*RATE_WID-1:0] rate_i;
  logic [REFRAC_WID-1:0]    refrac_i;
  logic [RATE_WID-1:0]      rand_i;
  logic                     spike_valid_o;
  logic [2:0]               spike_addr_o;
  logic                     spike_ready_i;
  logic                     round_o;
  logic [DROP_WID-1:0]      drop_cnt_o;

  poisson_spike_encoder #(
    .N_CH(N_CH), .RATE_WID(RATE_WID), .REFRAC_WID(REFRAC_WID),
    .FIFO_DEPTH(FIFO_DEPTH), .DROP_WID(DROP_WID)
  ) dut (
    .clk(clk), .rst_i(rst_i), .en_i(en_i), .rate_i(rate_i), .refrac_i(refrac_i),
    .rand_i(rand_i), .spike_valid_o(spike_valid_o), .spike_addr_o(spike_addr_o),
    .spike_ready_i(spike_ready_i), .round_o(round_o), .drop_cnt_o(drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [2:0] sb [$];
  int         m_ch;
  int         m_ref [N_CH];
  int         m_drop;
  int         cyc;
  int         vld_cyc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic void model_clear();
    sb.delete();
    m_ch   = 0;
    m_drop = 0;
    for (int k = 0; k < N_CH; k++) m_ref[k] = 0;
  endfunction

  // One clock: predict the edge effect, advance the clock, then compare.
  task automatic step();
    bit pop, fire, push, exp_round;
    int c;
    pop       = (sb.size() != 0) && spike_ready_i;
    fire      = 1'b0;
    push      = 1'b0;
    exp_round = 1'b0;
    c         = m_ch;
    if (en_i) begin
      if (m_ref[c] != 0) m_ref[c] = m_ref[c] - 1;
      else if (int'(rand_i) < int'(rate_i[c*RATE_WID +: RATE_WID])) begin
        fire     = 1'b1;
        m_ref[c] = int'(refrac_i);
      end
      exp_round = (c == N_CH - 1);
      m_ch      = (c + 1) % N_CH;
    end
    if (fire) begin
      if (sb.size() < FIFO_DEPTH || pop) push = 1'b1;
      else if (m_drop != 255) m_drop++;
    end
    if (pop) void'(sb.pop_front());
    if (push) sb.push_back(c[2:0]);
    @(posedge clk);
    #1;
    cyc++;
    if (spike_valid_o === 1'b1) vld_cyc.push_back(cyc);
    check("valid", 32'(spike_valid_o), 32'(sb.size() != 0));
    if (sb.size() != 0) check("addr", 32'(spike_addr_o), 32'(sb[0]));
    check("round", 32'(round_o), 32'(exp_round));
    check("drop", 32'(drop_cnt_o), 32'(m_drop));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    en_i          = 1'($urandom);
    rate_i        = {$urandom, $urandom};
    refrac_i      = 4'($urandom);
    rand_i        = 6'($urandom);
    spike_ready_i = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(spike_valid_o), 0);
    check("rst_addr", 32'(spike_addr_o), 0);
    check("rst_round", 32'(round_o), 0);
    check("rst_drop", 32'(drop_cnt_o), 0);
    model_clear();
    vld_cyc.delete();
    cyc           = 0;
    en_i          = 1'b0;
    spike_ready_i = 1'b1;
    rate_i        = '0;
    refrac_i      = '0;
    rand_i        = '0;
    rst_i         = 1'b0;
  endtask

  task automatic set_all_rates(input logic [5:0] r);
    for (int k = 0; k < N_CH; k++) rate_i[k*RATE_WID +: RATE_WID] = r;
  endtask

  initial begin
    cyc = 0;
    model_clear();

    // Reset, then idle with enable low.
    do_reset();
    en_i = 1'b0;
    steps(10);
    check("idle_no_spikes", 32'(vld_cyc.size()), 0);

    // Deterministic fire on channel 3.
    do_reset();
    rate_i[3*RATE_WID +: RATE_WID] = 6'd10;
    rand_i = 6'd5;
    en_i   = 1'b1;
    steps(32);
    check("det_spike_count", 32'(vld_cyc.size()), 4);
    if (vld_cyc.size() >= 2) check("det_spike_gap", 32'(vld_cyc[1] - vld_cyc[0]), 8);

    // Threshold boundary: equal never fires, one below always fires.
    do_reset();
    set_all_rates(6'd20);
    rand_i = 6'd20;
    en_i   = 1'b1;
    steps(16);
    check("thr_eq_none", 32'(vld_cyc.size()), 0);
    rand_i = 6'd19;
    steps(16);
    check("thr_below_all", 32'(vld_cyc.size()), 16);
    set_all_rates(6'd0);
    rand_i = 6'd0;
    steps(3);
    vld_cyc.delete();
    steps(16);
    check("rate0_none", 32'(vld_cyc.size()), 0);
    rand_i = 6'd63;
    set_all_rates(6'd63);
    steps(16);
    check("rate63_rand63_none", 32'(vld_cyc.size()), 0);

    // Refractory: channel 0 fires every third visit.
    do_reset();
    rate_i[0 +: RATE_WID] = 6'd63;
    rand_i   = 6'd0;
    refrac_i = 4'd2;
    en_i     = 1'b1;
    steps(56);
    check("ref_count", 32'(vld_cyc.size()), 3);
    if (vld_cyc.size() == 3) begin
      check("ref_gap1", 32'(vld_cyc[1] - vld_cyc[0]), 24);
      check("ref_gap2", 32'(vld_cyc[2] - vld_cyc[1]), 24);
    end

    // Backpressure fills the FIFO and drops four spikes, then drains in order.
    do_reset();
    set_all_rates(6'd63);
    rand_i        = 6'd0;
    en_i          = 1'b1;
    spike_ready_i = 1'b0;
    steps(8);
    check("bp_drop4", 32'(drop_cnt_o), 4);
    spike_ready_i = 1'b1;
    steps(12);
    en_i = 1'b0;
    steps(6);
    check("bp_drained", 32'(spike_valid_o), 0);

    // Saturating drop counter, then reset asserted between clock edges.
    do_reset();
    set_all_rates(6'd63);
    rand_i        = 6'd0;
    en_i          = 1'b1;
    spike_ready_i = 1'b0;
    steps(300);
    check("sat_drop", 32'(drop_cnt_o), 255);
    rst_i = 1'b1;
    #2;
    check("async_drop", 32'(drop_cnt_o), 0);
    check("async_valid", 32'(spike_valid_o), 0);
    check("async_round", 32'(round_o), 0);
    @(posedge clk);
    #1;
    model_clear();
    rst_i = 1'b0;
    set_all_rates(6'd0);
    rate_i[0 +: RATE_WID] = 6'd63;
    spike_ready_i = 1'b1;
    vld_cyc.delete();
    cyc = 0;
    steps(2);
    check("post_rst_ch0", 32'(vld_cyc.size()), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
